// File: rtl/spi_master_tx_if.sv
// FIFO-side and pad-side signal bundle for spi_master_tx.
// SPI_MASTER_MISO_RX_EN adds the MISO receive signals.
interface spi_master_tx_if #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned MAX_BURST = 4
);
  localparam int unsigned WSW = $clog2(MAX_BURST + 1);

  logic                 enable;
  logic                 empty;
  logic [DATAWIDTH-1:0] read_data;
  logic                 read_en;
  logic                 sclk;
  logic                 mosi;
  logic                 cs_n;
  logic                 busy;
  logic                 done;
  logic [WSW-1:0]       words_sent;

`ifdef SPI_MASTER_MISO_RX_EN
  logic                 miso;
  logic [DATAWIDTH-1:0] rx_data;
  logic                 rx_valid;

  modport master (
    input  enable, empty, read_data, miso,
    output read_en, sclk, mosi, cs_n, busy, done, words_sent, rx_data, rx_valid
  );
  modport slave (
    output enable, empty, read_data, miso,
    input  read_en, sclk, mosi, cs_n, busy, done, words_sent, rx_data, rx_valid
  );
`else
  modport master (
    input  enable, empty, read_data,
    output read_en, sclk, mosi, cs_n, busy, done, words_sent
  );
  modport slave (
    output enable, empty, read_data,
    input  read_en, sclk, mosi, cs_n, busy, done, words_sent
  );
`endif
endinterface

// File: rtl/spi_master_tx.sv
// SPI master transmitter draining a FWFT FIFO, with bursts of words per chip-select frame.
// Optional MISO receive path enabled by SPI_MASTER_MISO_RX_EN.
module spi_master_tx #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned CLKDIV    = 2,
  parameter bit          CPOL      = 1'b0,
  parameter bit          CPHA      = 1'b0,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           rst,
  spi_master_tx_if.master bus
);
  localparam int unsigned WSW = $clog2(MAX_BURST + 1);
  localparam int unsigned HPW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int unsigned ECW = $clog2(2 * DATAWIDTH);

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, SHIFT, HOLD} state_e;

  state_e               state_q, state_d;
  logic [HPW-1:0]       hp_q, hp_d;
  logic [ECW-1:0]       ec_q, ec_d;
  logic [DATAWIDTH-1:0] sh_q, sh_d;
  logic                 sclk_q, sclk_d;
  logic                 cs_n_q, cs_n_d;
  logic                 mosi_q, mosi_d;
  logic                 done_pend_q, done_pend_d;
  logic                 done_q, done_d;
  logic [WSW-1:0]       ws_q, ws_d;

  logic tick, last_edge, leading, can_start;

  function automatic logic first_bit(input logic [DATAWIDTH-1:0] v);
    return MSB_FIRST ? v[DATAWIDTH-1] : v[0];
  endfunction

  function automatic logic [DATAWIDTH-1:0] shifted(input logic [DATAWIDTH-1:0] v);
    return MSB_FIRST ? {v[DATAWIDTH-2:0], 1'b0} : {1'b0, v[DATAWIDTH-1:1]};
  endfunction

  assign tick      = (hp_q == HPW'(CLKDIV - 1));
  assign last_edge = (ec_q == ECW'(2 * DATAWIDTH - 1));
  assign leading   = (sclk_q == CPOL);
  assign can_start = bus.enable && !bus.empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hp_q        <= '0;
      ec_q        <= '0;
      sh_q        <= '0;
      sclk_q      <= CPOL;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      done_pend_q <= 1'b0;
      done_q      <= 1'b0;
      ws_q        <= '0;
    end else begin
      state_q     <= state_d;
      hp_q        <= hp_d;
      ec_q        <= ec_d;
      sh_q        <= sh_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
      done_pend_q <= done_pend_d;
      done_q      <= done_d;
      ws_q        <= ws_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hp_d        = '0;
    ec_d        = ec_q;
    sh_d        = sh_q;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    done_pend_d = 1'b0;
    done_d      = done_pend_q;
    ws_d        = ws_q;

    case (state_q)
      IDLE: begin
        sclk_d = CPOL;
        cs_n_d = 1'b1;
        // done lags cs_n by a cycle; hold off a new frame until done is visible
        if (can_start && !done_pend_q) begin
          state_d = LOAD;
          ws_d    = '0;
        end
      end
      LOAD: begin
        sh_d   = bus.read_data;
        cs_n_d = 1'b0;
        ws_d   = ws_q + 1'b1;
        ec_d   = '0;
        if (!CPHA) begin
          mosi_d = first_bit(bus.read_data);
          sh_d   = shifted(bus.read_data);
        end
        // cs_n still high here only for the first word of a frame
        state_d = cs_n_q ? SETUP : SHIFT;
      end
      SETUP: begin
        hp_d = tick ? '0 : hp_q + 1'b1;
        if (tick) state_d = SHIFT;
      end
      SHIFT: begin
        hp_d = tick ? '0 : hp_q + 1'b1;
        if (tick) begin
          sclk_d = ~sclk_q;
          ec_d   = ec_q + 1'b1;
          if ((!CPHA && !leading && !last_edge) || (CPHA && leading)) begin
            mosi_d = first_bit(sh_q);
            sh_d   = shifted(sh_q);
          end
          if (last_edge) begin
            ec_d    = '0;
            state_d = (can_start && (ws_q < WSW'(MAX_BURST))) ? LOAD : HOLD;
          end
        end
      end
      HOLD: begin
        hp_d = tick ? '0 : hp_q + 1'b1;
        if (tick) begin
          cs_n_d      = 1'b1;
          mosi_d      = 1'b0;
          done_pend_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.read_en    = (state_q == LOAD);
  assign bus.busy       = (state_q != IDLE);
  assign bus.sclk       = sclk_q;
  assign bus.mosi       = mosi_q;
  assign bus.cs_n       = cs_n_q;
  assign bus.done       = done_q;
  assign bus.words_sent = ws_q;

`ifdef SPI_MASTER_MISO_RX_EN
  logic [DATAWIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATAWIDTH-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 sample_edge, last_sample;

  // miso is captured at the clock edge where sclk toggles, i.e. just before the pad edge
  assign sample_edge = (state_q == SHIFT) && tick && (leading != CPHA);
  assign last_sample = sample_edge &&
                       (CPHA ? last_edge : (ec_q == ECW'(2 * DATAWIDTH - 2)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    if (sample_edge) begin
      rx_sh_d = MSB_FIRST ? {rx_sh_q[DATAWIDTH-2:0], bus.miso}
                          : {bus.miso, rx_sh_q[DATAWIDTH-1:1]};
      if (last_sample) begin
        rx_data_d  = rx_sh_d;
        rx_valid_d = 1'b1;
      end
    end
  end

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
`endif
endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
Parametrised SPI master transmitter that drains a first-word-fall-through FIFO and serialises each word onto MOSI with a programmable SCLK divider, SPI mode (CPOL/CPHA) and bit order. Consecutive FIFO words can be sent back-to-back in one chip-select frame, up to a configurable burst limit. Sits between the TX FIFO and the SPI pads.

Parameters:
DATAWIDTH, 32, bits per word (>=2)
CLKDIV, 2, clk cycles per SCLK half-period (>=1); SCLK = clk/(2*CLKDIV)
CPOL, 0, SCLK idle level
CPHA, 0, 0: data valid before leading edge, updated on trailing edge; 1: updated on leading edge
MSB_FIRST, 1, 1: MSB shifted first; 0: LSB first
MAX_BURST, 4, max words per cs_n frame (1 = one word per frame)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
enable  in  1  permits new frames/words to start
empty  in  1  FIFO empty
read_data  in  DATAWIDTH  FIFO head word, valid while !empty
read_en  out  1  FIFO pop, one-cycle pulse
sclk  out  1  SPI clock
mosi  out  1  serial data
cs_n  out  1  chip select, active-low
busy  out  1  high from LOAD until return to IDLE
done  out  1  one-cycle pulse at end of frame
words_sent  out  $clog2(MAX_BURST+1)  words in current/last frame

Behaviour:
- Reset (async): sclk=CPOL, cs_n=1, mosi=0, read_en=0, busy=0, done=0, words_sent=0, state IDLE; internal counters cleared. Reset mid-frame aborts immediately; the partially sent word is lost (already popped).
- Half-period counter hp counts 0..CLKDIV-1 in SETUP/SHIFT/HOLD; "tick" when hp==CLKDIV-1; hp clears on state entry.
- IDLE: sclk=CPOL, cs_n=1. If enable && !empty -> LOAD; words_sent cleared on this transition.
- LOAD (1 cycle): read_en=1, shift register <= read_data, cs_n<=0, busy<=1, words_sent+1. CPHA=0: mosi <= first bit now. First word -> SETUP; burst continuation -> SHIFT.
- SETUP: cs_n low, sclk idle, one half-period (CLKDIV cycles) -> SHIFT.
- SHIFT: each tick toggles sclk; 2*DATAWIDTH edges per word. CPHA=0: mosi updates to next bit on each trailing edge except the last. CPHA=1: mosi updates on each leading edge (first bit on first leading edge). Bit order per MSB_FIRST. Word length = 2*DATAWIDTH*CLKDIV cycles.
- After final edge (sclk back at CPOL): if enable && !empty && words_sent<MAX_BURST -> LOAD (cs_n stays low); else -> HOLD.
- HOLD: one half-period with cs_n low, then cs_n<=1, done pulse 1 cycle, busy<=0, mosi<=0 -> IDLE. Next frame cannot start until the cycle after done.
- enable deassert mid-word: current word completes; frame then ends via HOLD.
- empty asserting mid-word: no effect until word end; frame then ends.
- read_en never asserts while empty=1; exactly one pop per transmitted word.

Optional Feature:
Macro SPI_MASTER_MISO_RX_EN. Defined: adds ports miso (in, 1), rx_data (out, DATAWIDTH), rx_valid (out, 1). miso sampled on each sample edge (leading if CPHA=0, trailing if CPHA=1), assembled in MSB_FIRST order; rx_data updates and rx_valid pulses one cycle after each word's last sample edge; both reset to 0. Undefined: ports and receive logic absent; TX behaviour identical.

Test Plan:
- DATAWIDTH=8, CLKDIV=2, mode 0, MSB first; FIFO holds 0xA5, enable=1 -> one read_en pulse, cs_n low, 8 rising edges, mosi sampled at rising edges = 1,0,1,0,0,1,0,1; done 1 cycle after cs_n rises; words_sent=1.
- Same config, CPOL=1, CPHA=1, MSB_FIRST=0, word 0x01 -> sclk idles high; bits on rising (trailing) edges = 1,0,0,0,0,0,0,0.
- MAX_BURST=4, FIFO holds 6 words -> frame 1 sends 4 words with cs_n continuously low and 4 read_en pulses; cs_n high ≥1 cycle; frame 2 sends 2 words; words_sent=4 then 2.
- Burst of 3 with empty asserting after word 2 pop -> frame ends after word 2; no read_en while empty; done pulse.
- rst asserted mid-word 3 of a burst -> same-cycle cs_n=1, sclk=CPOL, busy=0; after release, resumes with next FIFO word in a new frame.
- With SPI_MASTER_MISO_RX_EN, miso looped to mosi, send 0x3C -> rx_valid pulse, rx_data=0x3C.
